// File: rtl/uart_tx_arb.sv
// Round-robin arbiter feeding single bytes from N_REQ requesters into one UART transmitter.
// It also generates the transmitter's bit-tick enable from a programmable divisor.
module uart_tx_arb #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned DIV_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [DIV_W-1:0]     baud_div,
  output logic                 tx_wr_en,
  output logic [7:0]           tx_data,
  output logic                 tx_enb,
  input  logic                 tx_busy,
  output logic [2:0]           grant_id,
  output logic                 err_timeout
);

  localparam int unsigned ID_W       = 3;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned MAX_REQ    = 8;
  localparam int unsigned DATA_PAD_W = BYTE_W * MAX_REQ;
  localparam int unsigned TO_W       = 2;
  localparam logic [ID_W-1:0] LAST_RST = ID_W'(N_REQ - 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(3);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [DIV_W-1:0]        baud_cnt;
  logic [ID_W-1:0]         last_grant;
  logic [TO_W-1:0]         wait_cnt;
  logic [MAX_REQ-1:0]      valid_pad;
  logic [DATA_PAD_W-1:0]   data_pad;
  logic [ID_W-1:0]         cand;
  logic [ID_W-1:0]         winner;
  logic                    found;
  logic                    sel;
  logic                    timeout;

  // Padding to the maximum requester count keeps the dynamic selects full-width.
  assign valid_pad = MAX_REQ'(req_valid);
  assign data_pad  = DATA_PAD_W'(req_data);

  // Bit-tick divider; a counter left above a lowered divisor wraps immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      baud_cnt <= '0;
      tx_enb   <= 1'b0;
    end else begin
      tx_enb   <= (baud_cnt == baud_div);
      baud_cnt <= (baud_cnt >= baud_div) ? '0 : baud_cnt + DIV_W'(1);
    end
  end

  // Round-robin search starting one above the last granted requester.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = ID_W'((32'(last_grant) + 32'd1 + i) % N_REQ);
      if (!found && valid_pad[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    sel        = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE: begin
        if (found && !tx_busy) begin
          sel        = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: state_next = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_next = WAIT_DONE;
        end else if (wait_cnt == TO_LAST) begin
          timeout    = 1'b1;
          state_next = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Accept strobe is combinational and suppressed while reset is held.
  always_comb begin
    req_ready = '0;
    if (sel && rst) req_ready = N_REQ'(1) << winner;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_wr_en    <= 1'b0;
      tx_data     <= '0;
      grant_id    <= '0;
      last_grant  <= LAST_RST;
      wait_cnt    <= '0;
      err_timeout <= 1'b0;
    end else begin
      tx_wr_en <= sel;
      if (sel) begin
        tx_data    <= data_pad[{winner, 3'b000} +: BYTE_W];
        grant_id   <= winner;
        last_grant <= winner;
      end
      if (state == WAIT_BUSY && !tx_busy) wait_cnt <= wait_cnt + TO_W'(1);
      else                                wait_cnt <= '0;
      if (timeout) err_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: directed phases plus random traffic, checked each cycle
// against a transaction-level model of grant timing, round-robin order and the bit tick.
module tb_uart_tx_arb;

  localparam int unsigned N     = 4;
  localparam int unsigned DIV_W = 16;
  localparam int          NEVER = 1 << 30;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [8*N-1:0]    req_data;
  logic [N-1:0]      req_ready;
  logic [DIV_W-1:0]  baud_div;
  logic              tx_wr_en;
  logic [7:0]        tx_data;
  logic              tx_enb;
  logic              tx_busy;
  logic [2:0]        grant_id;
  logic              err_timeout;

  int checks   = 0;
  int failures = 0;

  // Transmitter stand-in: busy for frame_len cycles after each load unless dead.
  int   busy_cnt;
  int   frame_len;
  logic dead;
  logic force_busy;

  // Model state.
  int         cyc;
  int         next_free;
  int         wr_cyc;
  int         err_at;
  int         m_last;
  int         bd;
  logic [7:0] m_data;
  logic [2:0] m_gid;
  int         grants[$];

  always #5 clk = ~clk;

  uart_tx_arb #(.N_REQ(N), .DIV_W(DIV_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .baud_div   (baud_div),
    .tx_wr_en   (tx_wr_en),
    .tx_data    (tx_data),
    .tx_enb     (tx_enb),
    .tx_busy    (tx_busy),
    .grant_id   (grant_id),
    .err_timeout(err_timeout)
  );

  always @(posedge clk or negedge rst) begin
    if (!rst)                      busy_cnt <= 0;
    else if (tx_wr_en && !dead)    busy_cnt <= frame_len;
    else if (busy_cnt != 0)        busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0) || force_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Winner = valid requester at the smallest forward distance from last grant.
  function automatic int pick(input logic [N-1:0] v, input int last);
    int best   = -1;
    int best_d = N;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        int d;
        d = (i - last - 1 + 2 * N) % N;
        if (d < best_d) begin
          best_d = d;
          best   = i;
        end
      end
    end
    return best;
  endfunction

  // Check one cycle (inputs already driven), update the model, advance to next negedge.
  task automatic tick();
    logic [N-1:0] exp_rdy;
    logic         gnt;
    int           w;
    #1;
    gnt     = (cyc >= next_free) && !tx_busy && (req_valid != '0);
    w       = gnt ? pick(req_valid, m_last) : 0;
    exp_rdy = '0;
    if (gnt) exp_rdy[w] = 1'b1;
    chk("req_ready",   32'(req_ready),   32'(exp_rdy));
    chk("tx_wr_en",    32'(tx_wr_en),    32'(cyc == wr_cyc));
    chk("tx_data",     32'(tx_data),     32'(m_data));
    chk("grant_id",    32'(grant_id),    32'(m_gid));
    chk("err_timeout", 32'(err_timeout), 32'(cyc >= err_at));
    chk("tx_enb",      32'(tx_enb),      32'(cyc >= 1 && (cyc % (bd + 1)) == 0));
    if (gnt) begin
      grants.push_back(w);
      m_last    = w;
      wr_cyc    = cyc + 1;
      m_data    = 8'(req_data >> (8 * w));
      m_gid     = 3'(w);
      next_free = cyc + (dead ? 6 : 3 + frame_len);
      if (dead && (cyc + 6) < err_at) err_at = cyc + 6;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset(input int new_bd);
    rst = 1'b0;
    #1;
    chk("rst_tx_wr_en",    32'(tx_wr_en),    32'd0);
    chk("rst_tx_enb",      32'(tx_enb),      32'd0);
    chk("rst_tx_data",     32'(tx_data),     32'd0);
    chk("rst_req_ready",   32'(req_ready),   32'd0);
    chk("rst_grant_id",    32'(grant_id),    32'd0);
    chk("rst_err_timeout", 32'(err_timeout), 32'd0);
    baud_div   = DIV_W'(new_bd);
    bd         = new_bd;
    dead       = 1'b0;
    force_busy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst       = 1'b1;
    cyc       = 0;
    next_free = 0;
    wr_cyc    = -1;
    err_at    = NEVER;
    m_last    = N - 1;
    m_data    = '0;
    m_gid     = '0;
  endtask

  task automatic wait_free();
    req_valid = '0;
    for (int k = 0; k < 30 && cyc < next_free; k++) tick();
    chk("wait_free_bound", 32'(cyc >= next_free), 32'd1);
  endtask

  initial begin
    int rr_exp[5];
    rr_exp     = '{0, 1, 2, 3, 0};
    rst        = 1'b1;
    req_valid  = '0;
    req_data   = '0;
    baud_div   = DIV_W'(3);
    frame_len  = 2;
    dead       = 1'b0;
    force_busy = 1'b0;
    #2;
    do_reset(3);

    // Round robin with all requesters continuously valid.
    req_valid = 4'hF;
    req_data  = 32'h44_33_22_11;
    grants.delete();
    repeat (40) tick();
    chk("rr_count", 32'(grants.size() >= 5), 32'd1);
    for (int i = 0; i < 5 && i < grants.size(); i++) chk("rr_order", 32'(grants[i]), 32'(rr_exp[i]));

    // Single requester with a 10-cycle frame.
    wait_free();
    frame_len = 10;
    req_data  = 32'hEE_DD_CC_5A;
    req_valid = 4'b0001;
    grants.delete();
    repeat (30) tick();
    chk("single_first", 32'(grants.size() >= 1 ? grants[0] : -1), 32'd0);

    // Busy seen in IDLE blocks selection until it drops.
    wait_free();
    force_busy = 1'b1;
    req_valid  = 4'b0100;
    grants.delete();
    repeat (5) tick();
    force_busy = 1'b0;
    repeat (4) tick();
    chk("busy_block_grant", 32'(grants.size() >= 1 ? grants[0] : -1), 32'd2);
    wait_free();

    // Transmitter never goes busy: timeout, then the flag stays set.
    dead      = 1'b1;
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    repeat (8) tick();
    wait_free();
    dead = 1'b0;
    repeat (3) tick();
    chk("err_sticky", 32'(err_timeout), 32'd1);

    // Requester 2 pulses only while a frame is in flight.
    frame_len = 10;
    req_valid = 4'b0001;
    grants.delete();
    tick();
    req_valid = '0;
    repeat (4) tick();
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    repeat (15) tick();
    chk("withdrawn_grants", 32'(grants.size()), 32'd1);

    // Random traffic in chunks with varying frame lengths.
    for (int c = 0; c < 6; c++) begin
      wait_free();
      frame_len = int'($urandom_range(1, 6));
      dead      = (c == 3);
      repeat (50) begin
        req_valid = N'($urandom);
        req_data  = $urandom;
        tick();
      end
    end
    wait_free();
    dead = 1'b0;

    // Reset in the middle of a frame, then a lone request from requester 3.
    frame_len = 10;
    req_valid = 4'b0001;
    tick();
    req_valid = 4'hF;
    repeat (4) tick();
    do_reset(0);
    req_valid = 4'b1000;
    req_data  = 32'hA7_00_00_00;
    grants.delete();
    repeat (10) tick();
    chk("post_reset_grant", 32'(grants.size() >= 1 ? grants[0] : -1), 32'd3);

    // Random traffic under a random divisor.
    do_reset(int'($urandom_range(0, 5)));
    frame_len = int'($urandom_range(1, 4));
    repeat (100) begin
      req_valid = N'($urandom);
      req_data  = $urandom;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
